// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, op codes, I/O addresses and payload type for the EX->MEM register.
// Address classification helpers live here so the datapath and any checker agree.
package ex_mem_reg_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned RWE_W  = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [RWE_W-1:0] RWE_NOTHING   = 2'b00;
    localparam logic [RWE_W-1:0] RWE_WRITE_REG = 2'b01;
    localparam logic [RWE_W-1:0] RWE_READ_MEM  = 2'b10;
    localparam logic [RWE_W-1:0] RWE_WRITE_MEM = 2'b11;

    localparam logic [DATA_W-1:0] ADDR_SERIAL_PORT         = 16'hBF00;
    localparam logic [DATA_W-1:0] ADDR_SERIAL_PORT_STATE   = 16'hBF01;
    localparam logic [DATA_W-1:0] ADDR_KEYBOARD            = 16'hBF02;
    localparam logic [DATA_W-1:0] ADDR_KEYBOARD_STATE      = 16'hBF03;
    localparam logic [DATA_W-1:0] ADDR_USER_CLK            = 16'hBF04;

    localparam logic [DATA_W-1:0] NOP_INSTR_DEF = 16'h0800;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  wreg_addr;
        logic [DATA_W-1:0] wdata;
        logic [RWE_W-1:0]  rwe;
    } ex_mem_t;

    function automatic logic is_io_addr(input logic [DATA_W-1:0] addr);
        return (addr == ADDR_SERIAL_PORT)    || (addr == ADDR_SERIAL_PORT_STATE) ||
               (addr == ADDR_KEYBOARD)       || (addr == ADDR_KEYBOARD_STATE)    ||
               (addr == ADDR_USER_CLK);
    endfunction

    function automatic logic is_mem_op(input logic [RWE_W-1:0] rwe);
        return (rwe == RWE_READ_MEM) || (rwe == RWE_WRITE_MEM);
    endfunction

    // Lower half of the address map is RAM2, which instruction fetch also uses.
    function automatic logic is_ram2_op(input logic [RWE_W-1:0] rwe, input logic [DATA_W-1:0] addr);
        return is_mem_op(rwe) && !addr[DATA_W-1] && !is_io_addr(addr);
    endfunction

    function automatic logic is_uart_write(input logic [RWE_W-1:0] rwe, input logic [DATA_W-1:0] addr);
        return (rwe == RWE_WRITE_MEM) && (addr == ADDR_SERIAL_PORT);
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-side inputs and MEM-side outputs of the EX->MEM pipeline register.
// master = surrounding pipeline, slave = the register itself.
interface ex_mem_reg_if;
    import ex_mem_reg_pkg::*;

    logic [DATA_W-1:0] exmemi_instr;
    logic [DATA_W-1:0] exmemi_pc;
    logic [DATA_W-1:0] exmemi_data;
    logic [REG_W-1:0]  exmemi_wreg_addr;
    logic [DATA_W-1:0] exmemi_write_to_mem_data;
    logic [RWE_W-1:0]  exmemi_rwe;
    logic              exmemi_flush;
    logic              exmemi_uart_writeable;

    logic [DATA_W-1:0] exmemo_instr;
    logic [DATA_W-1:0] exmemo_pc;
    logic [DATA_W-1:0] exmemo_data;
    logic [REG_W-1:0]  exmemo_wreg_addr;
    logic [DATA_W-1:0] exmemo_write_to_mem_data;
    logic [RWE_W-1:0]  exmemo_rwe;
    logic              exmemo_stall;
    logic              exmemo_ram2_busy;

    modport master (
        output exmemi_instr, exmemi_pc, exmemi_data, exmemi_wreg_addr,
               exmemi_write_to_mem_data, exmemi_rwe, exmemi_flush, exmemi_uart_writeable,
        input  exmemo_instr, exmemo_pc, exmemo_data, exmemo_wreg_addr,
               exmemo_write_to_mem_data, exmemo_rwe, exmemo_stall, exmemo_ram2_busy
    );

    modport slave (
        input  exmemi_instr, exmemi_pc, exmemi_data, exmemi_wreg_addr,
               exmemi_write_to_mem_data, exmemi_rwe, exmemi_flush, exmemi_uart_writeable,
        output exmemo_instr, exmemo_pc, exmemo_data, exmemo_wreg_addr,
               exmemo_write_to_mem_data, exmemo_rwe, exmemo_stall, exmemo_ram2_busy
    );

endinterface

// File: rtl/ex_mem_reg_mem_hold_fsm.sv
// MEM-stage hold controller: keeps a RAM2 access or a blocked UART write on the bus
// and tells the register when it may load the next instruction.
module ex_mem_reg_mem_hold_fsm
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned RAM2_HOLD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ram2_op,
    input  logic i_uart_write,
    input  logic i_uart_writeable,
    output logic o_accept_c,
    output logic o_stall_c,
    output logic o_ram2_busy_c
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HOLD_RAM2 = 2'd1;
    localparam logic [1:0] ST_WAIT_UART = 2'd2;

    // The IDLE cycle that sees the op is the first hold cycle, so HOLD_RAM2 covers the rest;
    // a window of 1 still spends one cycle in HOLD_RAM2 to leave IDLE.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM2_HOLD - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_uart_blocked;
    logic             w_idle_hold;
    logic             w_hold_last;

    assign w_uart_blocked = i_uart_write & ~i_uart_writeable;
    assign w_idle_hold    = i_ram2_op | w_uart_blocked;
    assign w_hold_last    = (r_cnt <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_ram2_op) begin
                    w_state_nxt = ST_HOLD_RAM2;
                    w_cnt_nxt   = CNT_LOAD;
                end else if (w_uart_blocked) begin
                    w_state_nxt = ST_WAIT_UART;
                end
            end
            ST_HOLD_RAM2: begin
                if (w_hold_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_WAIT_UART: begin
                if (i_uart_writeable) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Release edges (last hold cycle, UART ready) load the next instruction even though stall is high.
    always_comb begin
        o_accept_c    = 1'b0;
        o_stall_c     = 1'b0;
        o_ram2_busy_c = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_stall_c     = w_idle_hold;
                o_ram2_busy_c = i_ram2_op;
                o_accept_c    = ~w_idle_hold;
            end
            ST_HOLD_RAM2: begin
                o_stall_c     = 1'b1;
                o_ram2_busy_c = 1'b1;
                o_accept_c    = w_hold_last;
            end
            ST_WAIT_UART: begin
                o_stall_c  = 1'b1;
                o_accept_c = i_uart_writeable;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: latches EX results (or a bubble on flush) and freezes
// while the MEM stage must keep an access on the bus.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned       RAM2_HOLD = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic         exmemi_clk,
    input  logic         exmemi_rst,
    ex_mem_reg_if.slave  bus
);

    ex_mem_t r_mem;
    ex_mem_t w_ex;
    logic    w_accept;
    logic    w_stall;
    logic    w_ram2_busy;
    logic    w_ram2_op;
    logic    w_uart_write;

    // Flush keeps the PC so the bubble still tracks program order.
    always_comb begin
        w_ex = '{instr:     bus.exmemi_instr,
                 pc:        bus.exmemi_pc,
                 data:      bus.exmemi_data,
                 wreg_addr: bus.exmemi_wreg_addr,
                 wdata:     bus.exmemi_write_to_mem_data,
                 rwe:       bus.exmemi_rwe};
        if (bus.exmemi_flush) begin
            w_ex.instr     = NOP_INSTR;
            w_ex.data      = '0;
            w_ex.wreg_addr = '0;
            w_ex.wdata     = '0;
            w_ex.rwe       = RWE_NOTHING;
        end
    end

    always_ff @(posedge exmemi_clk or negedge exmemi_rst) begin
        if (!exmemi_rst) begin
            r_mem <= '{instr: NOP_INSTR, pc: '0, data: '0, wreg_addr: '0, wdata: '0, rwe: RWE_NOTHING};
        end else if (w_accept) begin
            r_mem <= w_ex;
        end
    end

    // Classification looks at the latched op, never at the EX inputs.
    assign w_ram2_op    = is_ram2_op(r_mem.rwe, r_mem.data);
    assign w_uart_write = is_uart_write(r_mem.rwe, r_mem.data);

    ex_mem_reg_mem_hold_fsm #(
        .RAM2_HOLD (RAM2_HOLD)
    ) u_mem_hold_fsm (
        .clk              (exmemi_clk),
        .rst_n            (exmemi_rst),
        .i_ram2_op        (w_ram2_op),
        .i_uart_write     (w_uart_write),
        .i_uart_writeable (bus.exmemi_uart_writeable),
        .o_accept_c       (w_accept),
        .o_stall_c        (w_stall),
        .o_ram2_busy_c    (w_ram2_busy)
    );

    assign bus.exmemo_instr             = r_mem.instr;
    assign bus.exmemo_pc                = r_mem.pc;
    assign bus.exmemo_data              = r_mem.data;
    assign bus.exmemo_wreg_addr         = r_mem.wreg_addr;
    assign bus.exmemo_write_to_mem_data = r_mem.wdata;
    assign bus.exmemo_rwe               = r_mem.rwe;
    assign bus.exmemo_stall             = w_stall;
    assign bus.exmemo_ram2_busy         = w_ram2_busy;

endmodule
